// File: rtl/apb_wait_mem_slave.sv
// APB3 completer fronting a word-addressed scratch memory with programmable
// wait states, address error responses and a saturating error counter.
module apb_wait_mem_slave #(
    parameter int unsigned               APB_ADDR_WIDTH = 32,
    parameter int unsigned               APB_DATA_WIDTH = 32,
    parameter int unsigned               MEM_DEPTH      = 64,
    parameter logic [APB_ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
    input  logic                      pclk,
    input  logic                      presetn,
    input  logic                      psel,
    input  logic                      penable,
    input  logic [APB_ADDR_WIDTH-1:0] paddr,
    input  logic                      pwrite,
    input  logic [APB_DATA_WIDTH-1:0] pwdata,
    output logic [APB_DATA_WIDTH-1:0] prdata,
    output logic                      pready,
    output logic                      pslverr,
    input  logic [3:0]                wait_cycles,
    output logic [7:0]                err_count,
    output logic                      busy
);
    localparam int unsigned IDX_W     = $clog2(MEM_DEPTH);
    localparam int unsigned MEM_BYTES = 4 * MEM_DEPTH;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned ECNT_W    = 8;

    typedef enum logic {
        IDLE,
        ACCESS
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [APB_ADDR_WIDTH-1:0]   addr_q;
    logic                        write_q;
    logic [APB_DATA_WIDTH-1:0]   wdata_q;
    logic [CNT_W-1:0]            cnt_q;
    logic [APB_DATA_WIDTH-1:0]   mem_q [MEM_DEPTH];

    logic [APB_ADDR_WIDTH-1:0]   offset;
    logic [IDX_W-1:0]            idx;
    logic                        addr_err;
    logic                        setup;
    logic                        waiting;

    // Address decode always works on the captured address, never the live bus.
    assign offset   = addr_q - BASE_ADDR;
    assign idx      = offset[IDX_W+1:2];
    assign addr_err = (addr_q[1:0] != 2'b00) || (addr_q < BASE_ADDR)
                   || (offset >= APB_ADDR_WIDTH'(MEM_BYTES));

    assign setup   = (state_q == IDLE) && psel && !penable;
    assign waiting = (state_q == ACCESS) && psel && penable && (cnt_q != '0);

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and the bus response; everything is quiet outside ACCESS.
    always_comb begin
        state_d = state_q;
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = '0;
        busy    = 1'b0;
        case (state_q)
            IDLE: begin
                if (psel && !penable) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                busy = 1'b1;
                if (!psel) begin
                    state_d = IDLE;
                end else if (penable && (cnt_q == '0)) begin
                    state_d = IDLE;
                    pready  = 1'b1;
                    pslverr = addr_err;
                    if (!addr_err && !write_q) begin
                        prdata = mem_q[idx];
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Transfer capture, wait countdown and error accounting.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            addr_q    <= '0;
            write_q   <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            err_count <= '0;
        end else begin
            if (setup) begin
                addr_q  <= paddr;
                write_q <= pwrite;
                wdata_q <= pwdata;
                cnt_q   <= wait_cycles;
            end else if (waiting) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            if (pready && pslverr && (err_count != '1)) begin
                err_count <= err_count + ECNT_W'(1);
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            for (int unsigned i = 0; i < MEM_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (pready && !pslverr && write_q) begin
            mem_q[idx] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_apb_wait_mem_slave.sv
// Bench for apb_wait_mem_slave: table of transfers plus hand-written abort,
// saturation and reset sequences, checked through an expected-result queue.
module tb_apb_wait_mem_slave;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned NVEC  = 13;

    logic          pclk = 1'b0;
    logic          presetn;
    logic          psel;
    logic          penable;
    logic [AW-1:0] paddr;
    logic          pwrite;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;
    logic [3:0]    wait_cycles;
    logic [7:0]    err_count;
    logic          busy;

    typedef struct {
        logic        wr;
        logic [31:0] rdata;
        logic        err;
        int          waits;
        logic [7:0]  ecnt;
    } exp_t;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  w;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [7:0]  exp_ecnt;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[NVEC];
    exp_t e;
    int   errors = 0;
    int   checks = 0;
    int   model_ecnt;

    apb_wait_mem_slave #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .MEM_DEPTH     (DEPTH),
        .BASE_ADDR     (32'h0000_0000)
    ) dut (
        .pclk       (pclk),
        .presetn    (presetn),
        .psel       (psel),
        .penable    (penable),
        .paddr      (paddr),
        .pwrite     (pwrite),
        .pwdata     (pwdata),
        .prdata     (prdata),
        .pready     (pready),
        .pslverr    (pslverr),
        .wait_cycles(wait_cycles),
        .err_count  (err_count),
        .busy       (busy)
    );

    always #5 pclk = ~pclk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One APB transfer; bus fields are scrambled after capture, and the
    // access phase is left asserted so a following transfer runs back-to-back.
    task automatic xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] w, input exp_t ex);
        exp_t got;
        bit   done;
        int   nwait;
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; wait_cycles = w;
        sb.push_back(ex);
        @(negedge pclk);
        chk("setup_quiet", 32'({busy, pready, pslverr}), 32'd0);
        @(posedge pclk); #1;
        penable = 1'b1; paddr = $urandom; pwdata = $urandom; wait_cycles = 4'($urandom);
        done  = 1'b0;
        nwait = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge pclk);
            if (pready) begin
                done = 1'b1;
                got  = sb.pop_front();
                chk("waits", 32'(nwait), 32'(got.waits));
                chk("pslverr", 32'(pslverr), 32'(got.err));
                if (!got.wr) chk("prdata", prdata, got.rdata);
                chk("busy_done", 32'(busy), 32'd1);
                chk("err_count", 32'(err_count), 32'(got.ecnt));
            end else begin
                chk("wait_quiet", 32'({pslverr, |prdata, ~busy}), 32'd0);
                nwait++;
                @(posedge pclk); #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL timeout: no pready for addr %h, got 0 expected 1", a);
            void'(sb.pop_front());
        end
    endtask

    task automatic go_idle();
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{1'b1, 32'h0000_0008, 32'hDEAD_BEEF, 4'd0,  32'h0,         1'b0, 8'd0};
        vecs[1]  = '{1'b0, 32'h0000_0008, 32'h0,         4'd0,  32'hDEAD_BEEF, 1'b0, 8'd0};
        vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0,         4'd3,  32'h0,         1'b0, 8'd0};
        vecs[3]  = '{1'b1, 32'h0000_0100, 32'h1111_1111, 4'd1,  32'h0,         1'b1, 8'd0};
        vecs[4]  = '{1'b1, 32'h0000_0002, 32'h2222_2222, 4'd0,  32'h0,         1'b1, 8'd1};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         4'd2,  32'h0,         1'b0, 8'd2};
        vecs[6]  = '{1'b1, 32'h0000_00FC, 32'hA5A5_0001, 4'd2,  32'h0,         1'b0, 8'd2};
        vecs[7]  = '{1'b0, 32'h0000_00FC, 32'h0,         4'd0,  32'hA5A5_0001, 1'b0, 8'd2};
        vecs[8]  = '{1'b0, 32'h0000_00FF, 32'h0,         4'd0,  32'h0,         1'b1, 8'd2};
        vecs[9]  = '{1'b1, 32'h0000_0010, 32'h0BAD_F00D, 4'd15, 32'h0,         1'b0, 8'd3};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         4'd1,  32'h0BAD_F00D, 1'b0, 8'd3};
        vecs[11] = '{1'b0, 32'hFFFF_FF00, 32'h0,         4'd0,  32'h0,         1'b1, 8'd3};
        vecs[12] = '{1'b0, 32'h0000_0004, 32'h0,         4'd0,  32'h0,         1'b0, 8'd4};

        psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0; pwdata = '0;
        wait_cycles = '0; presetn = 1'b0;
        repeat (3) @(posedge pclk);
        @(negedge pclk);
        chk("reset_flags", 32'({pready, pslverr, busy}), 32'd0);
        chk("reset_prdata", prdata, 32'd0);
        chk("reset_err_count", 32'(err_count), 32'd0);
        @(posedge pclk); #1;
        presetn = 1'b1;

        // Access phase without a preceding setup must be ignored.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b1; paddr = 32'h8;
        repeat (2) begin
            @(negedge pclk);
            chk("no_setup_ignored", 32'({pready, busy}), 32'd0);
        end

        for (int i = 0; i < int'(NVEC); i++) begin
            e = '{vecs[i].wr, vecs[i].exp_rdata, vecs[i].exp_err, int'(vecs[i].w), vecs[i].exp_ecnt};
            xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].w, e);
        end

        // Error counter saturation over back-to-back failing reads.
        model_ecnt = 4;
        for (int k = 0; k < 260; k++) begin
            e = '{1'b0, 32'h0, 1'b1, 0, 8'(model_ecnt)};
            xfer(1'b0, 32'h0000_0100, 32'h0, 4'd0, e);
            if (model_ecnt < 255) model_ecnt++;
        end
        e = '{1'b0, 32'hDEAD_BEEF, 1'b0, 0, 8'd255};
        xfer(1'b0, 32'h0000_0008, 32'h0, 4'd0, e);
        go_idle();
        @(negedge pclk);
        chk("err_count_sat", 32'(err_count), 32'd255);

        // Aborted write: psel dropped after one wait cycle.
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h14;
        pwdata = 32'h1234_5678; wait_cycles = 4'd3;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk);
        chk("abort_waiting", 32'({pready, busy}), 32'd1);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(negedge pclk);
        chk("abort_no_ready", 32'({pready, pslverr}), 32'd0);
        @(negedge pclk);
        chk("abort_idle", 32'({pready, busy}), 32'd0);
        e = '{1'b0, 32'h0, 1'b0, 2, 8'd255};
        xfer(1'b0, 32'h0000_0014, 32'h0, 4'd2, e);

        // Reset in the middle of a write's wait states.
        go_idle();
        @(posedge pclk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8;
        pwdata = 32'h0000_0055; wait_cycles = 4'd4;
        @(posedge pclk); #1;
        penable = 1'b1;
        @(negedge pclk); #2;
        presetn = 1'b0;
        #1;
        chk("rst_mid_flags", 32'({pready, pslverr, busy}), 32'd0);
        chk("rst_mid_prdata", prdata, 32'd0);
        chk("rst_mid_err_count", 32'(err_count), 32'd0);
        @(posedge pclk); #1;
        psel = 1'b0; penable = 1'b0;
        @(posedge pclk); #1;
        presetn = 1'b1;
        for (int k = 0; k < int'(DEPTH); k++) begin
            e = '{1'b0, 32'h0, 1'b0, 0, 8'd0};
            xfer(1'b0, 32'(4 * k), 32'h0, 4'd0, e);
        end
        go_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/apb_wait_mem_slave.md
Name: apb_wait_mem_slave

Overview:
- APB3 completer (responder) fronting a small word-addressed register memory, with a programmable number of wait states and error signalling.
- It is the far end of the SPI-to-APB bridge master: the bench target and on-chip scratch memory that the SPI slave path reads and writes.
- It inserts wait states, flags bad accesses via pslverr, and counts errors.

Parameters:
- APB_ADDR_WIDTH, 32, width of paddr.
- APB_DATA_WIDTH, 32, width of pwdata/prdata (word = APB_DATA_WIDTH/8 bytes, fixed 4 here).
- MEM_DEPTH, 64, number of 32-bit words; power of two, 2..256.
- BASE_ADDR, 32'h0000_0000, byte address of word 0; aligned to 4*MEM_DEPTH.

Ports:
- pclk  in  1  clock; all logic on rising edge.
- presetn  in  1  asynchronous active-low reset.
- psel  in  1  APB select.
- penable  in  1  APB access phase.
- paddr  in  APB_ADDR_WIDTH  byte address.
- pwrite  in  1  1 = write, 0 = read.
- pwdata  in  APB_DATA_WIDTH  write data.
- prdata  out  APB_DATA_WIDTH  read data; valid only while pready=1 on a read.
- pready  out  1  transfer completes this cycle.
- pslverr  out  1  error response; valid only while pready=1.
- wait_cycles  in  4  wait states inserted per transfer (0..15).
- err_count  out  8  saturating count of pslverr responses.
- busy  out  1  high from the captured setup phase through the completing cycle.

Behaviour:
- Reset (async, presetn=0): state IDLE, all MEM_DEPTH words = 0, err_count = 0, wait counter = 0. Combinational outputs prdata=0, pready=0, pslverr=0, busy=0 whenever state=IDLE.
- FSM states: IDLE, ACCESS.
- IDLE:
  - On psel=1 && penable=0 (setup), capture paddr, pwrite, pwdata and wait_cycles into a 4-bit counter, then go to ACCESS.
  - psel=1 && penable=1 while in IDLE (no setup seen) is ignored: pready stays 0 and the state stays IDLE.
- ACCESS, when psel=1 && penable=1:
  - If counter != 0: pready=0 and the counter decrements.
  - If counter == 0: pready=1 and state returns to IDLE next cycle.
- Latency: first access cycle completes when wait_cycles=0; total transfer = 2 + wait_cycles cycles including setup.
- ACCESS with psel=1 && penable=0 (setup held for more than one cycle): hold, counter does not decrement.
- ACCESS with psel=0 (aborted transfer): return to IDLE, no write, no error count, pready never asserted.
- Changes to wait_cycles, paddr or pwdata after capture have no effect on the current transfer.
- Error decode, evaluated on the captured address:
  - Error if the captured address is misaligned (addr[1:0] != 0).
  - Error if it is outside [BASE_ADDR, BASE_ADDR + 4*MEM_DEPTH).
  - Word index = (addr - BASE_ADDR) >> 2, truncated to log2(MEM_DEPTH) bits.
- Completing cycle (pready=1):
  - Error: pslverr=1, prdata=0, no memory write, err_count increments, saturating at 255 (255 stays 255).
  - Write, no error: mem[index] <= captured pwdata at this clock edge.
  - Read, no error: prdata = mem[index] combinationally.
- Back-to-back transfers: a new setup in the cycle after completion is accepted from IDLE with no gap cycle required. A read immediately after a write to the same index returns the new data.
- pready, pslverr and prdata are 0 in every cycle other than the completing cycle.
- Reset asserted mid-transfer: immediate return to IDLE, memory cleared, no partial write.

Test Plan:
- wait_cycles=0, write 32'hDEAD_BEEF to BASE_ADDR+8, then read BASE_ADDR+8 -> each transfer is 2 cycles, pready high on the first penable cycle, prdata=32'hDEAD_BEEF, pslverr=0.
- wait_cycles=3, read BASE_ADDR+0 after reset -> pready low for exactly 3 penable cycles then high for 1, prdata=0; wait_cycles changed to 0 mid-access does not shorten the transfer.
- Write to BASE_ADDR+4*MEM_DEPTH (=0x100), then to BASE_ADDR+2 -> both complete with pslverr=1, err_count=2, mem unchanged (reading word 0 returns 0).
- 260 consecutive erroring reads -> err_count stops at 255; next valid read has pslverr=0.
- psel dropped after 1 wait cycle of a write of 32'h1234_5678 to word 5 -> no pready, word 5 still 0, err_count unchanged; next setup accepted normally.
- presetn pulsed low during ACCESS of a write -> outputs 0 immediately, busy=0, all words read back 0 afterwards.
